w_ptr_ctrl: RTL and testbench
=============================

Name: w_ptr_ctrl

Overview:
- Parametrised write-domain pointer and flag controller for the asynchronous FIFO; successor to the fixed 4-bit write-pointer handler.
- Owns the binary and Gray write pointers and the RAM write address.
- Synchronises the read-domain Gray pointer internally and produces:
  - registered full,
  - fill level,
  - programmable almost-full,
  - a sticky overflow error.
- Sits in the write clock domain between the FIFO write interface and the dual-port RAM.

Parameters:
- ADDR_W, 3, RAM address width. FIFO depth is 2^ADDR_W. Pointers are ADDR_W+1 bits. Legal range 2..12.
- SYNC_STAGES, 2, number of flops in the read-pointer synchroniser. Legal range 2..4.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous active-low reset.
- w_en  input  1  write request.
- gr_ptr_async  input  ADDR_W+1  Gray read pointer from the read domain (unsynchronised).
- af_thresh  input  ADDR_W+1  almost-full threshold in words. Quasi-static.
- ovf_clr  input  1  clears the overflow flag.
- w_accept  output  1  combinational: w_en & !full. This is the RAM write strobe.
- w_addr  output  ADDR_W  RAM write address, equal to bw_ptr[ADDR_W-1:0].
- bw_ptr  output  ADDR_W+1  binary write pointer.
- gw_ptr  output  ADDR_W+1  Gray write pointer, sent to the read domain.
- full  output  1  FIFO full (registered).
- almost_full  output  1  level_next >= af_thresh (registered).
- level  output  ADDR_W+1  words held, as seen from the write side (registered).
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst low, asynchronous):
  - bw_ptr, gw_ptr, level, full, almost_full and overflow are all 0.
  - All synchroniser flops are 0.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
- Synchroniser:
  - gr_ptr_async passes through SYNC_STAGES flops to give gr_ptr_s.
  - A change on gr_ptr_async is reflected in full, level and almost_full exactly SYNC_STAGES+1 rising edges later.
- Read pointer decode: rd_bin = gray2bin(gr_ptr_s), computed combinationally (XOR prefix from the MSB).
- Next-state equations:
  - w_inc = w_en & !full.
  - bw_ptr_next = bw_ptr + w_inc, modulo 2^(ADDR_W+1). Wrap from all-ones to 0 is natural.
  - gw_ptr_next = (bw_ptr_next >> 1) ^ bw_ptr_next.
  - full_next = (gw_ptr_next == {~gr_ptr_s[ADDR_W:ADDR_W-1], gr_ptr_s[ADDR_W-2:0]}).
  - level_next = (bw_ptr_next - rd_bin), modulo 2^(ADDR_W+1). Its range is 0..2^ADDR_W.
  - almost_full_next = (level_next >= af_thresh). af_thresh = 0 forces almost_full high. af_thresh > 2^ADDR_W forces it low.
- All of the above are registered on the rising edge of clk.
- Full and write timing:
  - full is based on the pointer after the current write. It therefore asserts on the edge that accepts the last free word.
  - No accepted write can overrun the FIFO.
- Write while full: w_en=1 with full=1 leaves the pointers unchanged, sets overflow on the next edge, and gives w_accept=0.
- Overflow clear:
  - ovf_clr=1 clears overflow on the next edge.
  - If ovf_clr and a new overflow event occur in the same cycle, the set wins.
- Read pointer movement:
  - full deasserts SYNC_STAGES+1 edges after gr_ptr_async advances.
  - level may be pessimistic (too high) by the synchroniser latency. It must never under-report.
- Gray invariant: gw_ptr changes by at most one bit per clock, including across the wrap.

Test Plan (ADDR_W=3, SYNC_STAGES=2):
1. Reset:
   - Stimulus: assert rst=0 mid-burst.
   - Required: all outputs 0 immediately. After release, the first write gives bw_ptr=1, gw_ptr=0001, level=1.
2. Fill:
   - Stimulus: gr_ptr_async=0, eight consecutive writes.
   - Required: full=1 on the 8th accepting edge, level=8, bw_ptr=1000, gw_ptr=1100. A 9th w_en gives w_accept=0.
3. Overflow:
   - Stimulus: hold w_en=1 while full for 3 cycles.
   - Required: pointers frozen and overflow=1. ovf_clr with w_en=0 clears it. ovf_clr together with w_en&full keeps it at 1.
4. Drain visibility:
   - Stimulus: while full, set gr_ptr_async=gray(3)=0010.
   - Required: full=0 and level=5 exactly 3 edges later. Earlier edges still show full=1.
5. Wrap:
   - Stimulus: 20 writes while the read pointer tracks 4 words behind.
   - Required: bw_ptr wraps 1111 to 0000, gw_ptr goes 1000 to 0000, full never asserts, and a single-bit Gray change is checked every cycle.
6. Almost-full:
   - Stimulus: af_thresh=6, reads held, fill one word at a time.
   - Required: almost_full rises on the edge where level reaches 6. With af_thresh=0 it is high from the first edge after reset; with af_thresh=9 it never asserts.

Source files
------------

// File: rtl/w_ptr_if.sv
// ---------------------------------------------------------------------------
// w_ptr_if : FIFO write-side bundle for w_ptr_ctrl.
//   master : the write client / environment. It drives w_en, ovf_clr,
//            af_thresh and the unsynchronised read-domain Gray pointer.
//   slave  : w_ptr_ctrl. It returns the write strobe, the RAM address,
//            the pointers and the status flags.
// ---------------------------------------------------------------------------
interface w_ptr_if #(
  parameter int ADDR_W = 3
);
  logic              w_en;          // write request
  logic [ADDR_W:0]   gr_ptr_async;  // Gray read pointer, read clock domain
  logic [ADDR_W:0]   af_thresh;     // almost-full threshold in words (quasi-static)
  logic              ovf_clr;       // clear sticky overflow
  logic              w_accept;      // RAM write strobe (w_en & !full)
  logic [ADDR_W-1:0] w_addr;        // RAM write address
  logic [ADDR_W:0]   bw_ptr;        // binary write pointer
  logic [ADDR_W:0]   gw_ptr;        // Gray write pointer, to read domain
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   level;         // words held, write-side view
  logic              overflow;      // sticky write-while-full

  modport master (
    output w_en, gr_ptr_async, af_thresh, ovf_clr,
    input  w_accept, w_addr, bw_ptr, gw_ptr, full, almost_full, level, overflow
  );

  modport slave (
    input  w_en, gr_ptr_async, af_thresh, ovf_clr,
    output w_accept, w_addr, bw_ptr, gw_ptr, full, almost_full, level, overflow
  );
endinterface

// File: rtl/w_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// w_ptr_ctrl : write-domain pointer and flag controller of an async FIFO.
//   Parameters : ADDR_W      RAM address width, depth 2^ADDR_W (legal 2..12)
//                SYNC_STAGES read-pointer synchroniser depth (legal 2..4)
//   Ports      : clk  write-domain clock
//                rst  asynchronous active-low reset
//                bus  w_ptr_if.slave. It carries the write request, the raw
//                     read Gray pointer, the threshold and the overflow clear
//                     in, and returns the write strobe, the address, the
//                     pointers, full, almost_full, level and overflow out.
// Flags are computed from the pointer after the current write, so full
// rises on the edge that consumes the last free word.
// ---------------------------------------------------------------------------
module w_ptr_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  w_ptr_if.slave   bus
);
  localparam int PW = ADDR_W + 1;
  // Full when the write Gray pointer equals the read Gray pointer with the
  // two MSBs inverted, i.e. exactly one lap ahead.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] gr_ptr_s, rd_bin;
  logic [PW-1:0] bw_q, gw_q, level_q;
  logic          full_q, af_q, ovf_q;
  logic [PW-1:0] bw_next, gw_next, level_next;
  logic          w_inc, full_next, af_next, ovf_next;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign gr_ptr_s = sync_q[SYNC_STAGES-1];
  assign rd_bin   = gray2bin(gr_ptr_s);

  always_comb begin
    // NOTE: every output of this block is assigned unconditionally before
    // any if, so no path can leave a value held and no latch is inferred.
    w_inc      = bus.w_en & ~full_q;
    bw_next    = bw_q + {{ADDR_W{1'b0}}, w_inc};
    gw_next    = (bw_next >> 1) ^ bw_next;
    full_next  = (gw_next == (gr_ptr_s ^ FULL_MASK));
    level_next = bw_next - rd_bin;
    af_next    = (level_next >= bus.af_thresh);
    ovf_next   = ovf_q;
    // A new overflow event takes priority over a clear in the same cycle.
    if (bus.w_en && full_q) ovf_next = 1'b1;
    else if (bus.ovf_clr)   ovf_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the synchroniser flops are reset as well, so a stale read
      // pointer cannot leak into the flags after reset is released.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bw_q    <= '0;
      gw_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the
      // pre-edge value, which the synchroniser shift chain depends on.
      sync_q[0] <= bus.gr_ptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bw_q    <= bw_next;
      gw_q    <= gw_next;
      level_q <= level_next;
      full_q  <= full_next;
      af_q    <= af_next;
      ovf_q   <= ovf_next;
    end
  end

  assign bus.w_accept    = w_inc;
  assign bus.w_addr      = bw_q[ADDR_W-1:0];
  assign bus.bw_ptr      = bw_q;
  assign bus.gw_ptr      = gw_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.level       = level_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_w_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_w_ptr_ctrl : scoreboard bench for w_ptr_ctrl (ADDR_W=3, SYNC_STAGES=2).
// The driver applies one cycle of stimulus, pushes the outputs the DUT must
// show in that cycle, and advances a word-count model. The monitor pops one
// record per cycle on the falling edge and compares it.
// ---------------------------------------------------------------------------
module tb_w_ptr_ctrl;
  localparam int ADDR_W = 3;
  localparam int SYNC   = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PMOD   = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  w_ptr_if #(.ADDR_W(ADDR_W)) bus ();

  w_ptr_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int bw;
    int level;
    bit full;
    bit af;
    bit ovf;
    bit acc;
    bit fresh;  // first record after reset, skip the Gray step check
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: total accepted words and total read count seen after the
  // synchroniser delay. level is the plain difference of the two.
  int m_w, m_level, af_th, rd_total;
  bit m_full, m_af, m_ovf, fresh_flag;
  int sync_q[$];

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_advance(input bit we, input bit clr, input int rc);
    int rd_vis;
    bit acc;
    acc = we && !m_full;
    if (we && m_full) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    m_w     = m_w + int'(acc);
    rd_vis  = sync_q.pop_front();
    sync_q.push_back(rc);
    m_level = m_w - rd_vis;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= af_th);
  endtask

  task automatic step(input bit we, input bit clr, input int rc);
    exp_t e;
    @(posedge clk); #1;
    bus.w_en         = we;
    bus.ovf_clr      = clr;
    bus.gr_ptr_async = 4'(gray(rc % PMOD));
    rd_total         = rc;
    e.bw    = m_w % PMOD;
    e.level = m_level;
    e.full  = m_full;
    e.af    = m_af;
    e.ovf   = m_ovf;
    e.acc   = we && !m_full;
    e.fresh = fresh_flag;
    sb.push_back(e);
    fresh_flag = 1'b0;
    model_advance(we, clr, rc);
  endtask

  task automatic do_reset(input int thresh);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.w_en = 1'b0; bus.ovf_clr = 1'b0; bus.gr_ptr_async = '0;
    rd_total = 0;
    #1;
    check("rst_bw_ptr",   32'(bus.bw_ptr), 0);
    check("rst_gw_ptr",   32'(bus.gw_ptr), 0);
    check("rst_w_addr",   32'(bus.w_addr), 0);
    check("rst_level",    32'(bus.level), 0);
    check("rst_full",     32'(bus.full), 0);
    check("rst_af",       32'(bus.almost_full), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_w_accept", 32'(bus.w_accept), 0);
    bus.af_thresh = 4'(thresh);
    af_th   = thresh;
    m_w     = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    sync_q  = {};
    for (int i = 0; i < SYNC; i++) sync_q.push_back(0);
    #4;
    rst = 1'b1;
    fresh_flag = 1'b1;
    model_advance(1'b0, 1'b0, 0);  // idle edge ahead of the next step
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   prev_gw = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bw_ptr",      32'(bus.bw_ptr),      32'(e.bw));
        check("gw_ptr",      32'(bus.gw_ptr),      32'(gray(e.bw)));
        check("w_addr",      32'(bus.w_addr),      32'(e.bw % DEPTH));
        check("level",       32'(bus.level),       32'(e.level));
        check("full",        32'(bus.full),        32'(e.full));
        check("almost_full", 32'(bus.almost_full), 32'(e.af));
        check("overflow",    32'(bus.overflow),    32'(e.ovf));
        check("w_accept",    32'(bus.w_accept),    32'(e.acc));
        if (!e.fresh)
          check("gray_one_bit", 32'($countones(4'(bus.gw_ptr) ^ 4'(prev_gw)) <= 1), 1);
        prev_gw = int'(bus.gw_ptr);
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    bus.w_en = 1'b0; bus.ovf_clr = 1'b0; bus.gr_ptr_async = '0; bus.af_thresh = 4'd6;
    m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; af_th = 6;
    rd_total = 0; fresh_flag = 1'b1;

    // Reset mid-burst, then restart writing.
    do_reset(6);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    do_reset(6);

    // Fill one word at a time with af_thresh=6, then run into full.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
    end
    step(1'b1, 1'b0, 0);                       // 9th request refused
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);                       // clear
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);                       // set again
    step(1'b1, 1'b1, 0);                       // set beats clear
    step(1'b0, 1'b0, 0);

    // Drain visibility: read pointer jumps to 3 while full.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3);

    // Wrap with the read pointer trailing four words behind.
    do_reset(6);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, (m_w > 4) ? m_w - 4 : 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, m_w);

    // Threshold extremes.
    do_reset(0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    do_reset(9);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 0);

    // Randomised traffic with a monotonic read pointer never ahead of writes.
    do_reset(int'($urandom_range(0, 9)));
    for (int i = 0; i < 400; i++) begin
      int rc;
      rc = rd_total;
      if ($urandom_range(0, 2) == 0 && rc < m_w)
        rc = rc + int'($urandom_range(1, 32'(m_w - rc)));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rc);
      if (i == 200) do_reset(int'($urandom_range(0, 9)));
    end

    @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
